// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state type.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider8_rb_sub.sv
// rb_sub: combinational WIDTH-bit ripple-borrow subtractor built from a chain of
// one-bit full subtractors.
//   a, b    : operands
//   diff    : a - b (modulo 2**WIDTH)
//   borrow  : high when b > a
module rb_sub #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] bw;

  assign bw[0] = 1'b0;

  // One full subtractor per bit; borrow ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow = bw[WIDTH];

endmodule

// File: rtl/seq_divider8.sv
// seq_divider8: radix-2 restoring unsigned divider, one quotient bit per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request a division (ignored while busy)
//   dividend, divisor   : operands, captured when start is accepted
//   busy                : high while iterating
//   done                : one-cycle result-valid pulse
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : captured divisor was zero (quotient all ones, remainder = dividend)
module seq_divider8
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = WIDTH + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // dividend bits shift out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dsr;
  logic [RW-1:0]    rem_r;

  logic [RW-1:0]    r_shift;
  logic [RW-1:0]    t;
  logic             bo;
  logic [RW-1:0]    r_next;
  logic [WIDTH-1:0] q_next;

  // Bring the next dividend bit into the partial remainder.
  assign r_shift = (rem_r << 1) | RW'(dvd[WIDTH-1]);

  rb_sub #(.WIDTH(RW)) u_sub (
    .a      (r_shift),
    .b      ({1'b0, dsr}),
    .diff   (t),
    .borrow (bo)
  );

  // Restore on borrow; quotient bit is the inverted borrow.
  assign r_next = bo ? r_shift : t;
  assign q_next = {dvd[WIDTH-2:0], ~bo};

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            dvd   <= dividend;
            dsr   <= divisor;
            rem_r <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              // Zero divisor resolves immediately without iterating.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_r <= r_next;
          dvd   <= q_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed cases plus a random sweep
// against an arithmetic reference model.
module tb_seq_divider8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int unsigned n_checks;
  int unsigned n_pass;

  seq_divider8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present operands with start for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done (bounded), checking latency, busy cycles and results against the model.
  task automatic wait_done(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                           input string tag, input bit full);
    int n;
    int nbusy;
    int eq, er;
    n = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    if (b == 0) begin
      eq = 255;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
    if (full) begin
      check({tag, "_busycyc"}, nbusy, exp_lat);
      check({tag, "_busy_at_done"}, busy, 0);
      if (b != 0) begin
        check({tag, "_identity"}, quotient * b + remainder, a);
        check({tag, "_rem_lt_div"}, (remainder < b) ? 1 : 0, 1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // 200 / 7 and results hold afterwards
    issue(200, 7);
    wait_done(200, 7, 8, "d200_7", 1'b1);
    repeat (3) @(negedge clk);
    check("hold_done", done, 0);
    check("hold_quo", quotient, 28);
    check("hold_rem", remainder, 4);

    issue(255, 1);   wait_done(255, 1, 8, "d255_1", 1'b1);   @(negedge clk);
    issue(5, 9);     wait_done(5, 9, 8, "d5_9", 1'b1);       @(negedge clk);
    issue(255, 255); wait_done(255, 255, 8, "d255_255", 1'b1); @(negedge clk);

    // Divide by zero: done right after acceptance, busy never rises
    issue(37, 0);
    wait_done(37, 0, 0, "dz37", 1'b1);
    @(negedge clk);
    check("dz_done_clears", done, 0);

    // Start during CALC is ignored
    issue(100, 3);
    @(negedge clk);
    start = 1'b1; dividend = 9; divisor = 2;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, 3, 6, "ign100_3", 1'b0);
    // Back-to-back start in the DONE cycle
    issue(9, 2);
    check("b2b_busy", busy, 1);
    wait_done(9, 2, 8, "b2b9_2", 1'b1);
    @(negedge clk);

    // Reset mid-CALC aborts with no done pulse
    issue(200, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quo", quotient, 0);
    check("abort_rem", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    issue(50, 6);
    wait_done(50, 6, 8, "d50_6", 1'b1);
    @(negedge clk);

    // Random sweep, occasionally back-to-back and occasionally zero divisor
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (($urandom % 16) == 0) b = 0;
      issue(a, b);
      wait_done(a, b, (b == 0) ? 0 : 8, "rnd", 1'b1);
      if ($urandom % 2) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
